// File: rtl/mem_unit_if.sv
// Request/response bus between the load/store control FSMs and mem_unit.
//   MEM_EN       access request strobe (controller -> memory)
//   MEM_RW       1 = read, 0 = write (controller -> memory)
//   mem_addr     word address from MAR (controller -> memory)
//   mem_data_in  store data from MDR (controller -> memory)
//   mem_data_out read data toward MDR (memory -> controller)
//   MFC          memory-function-complete; high while an access is in flight
//   busy         mirrors MFC for other bus masters
interface mem_unit_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  MEM_EN;
  logic                  MEM_RW;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [DATA_WIDTH-1:0] mem_data_out;
  logic                  MFC;
  logic                  busy;

  modport master (
    output MEM_EN, MEM_RW, mem_addr, mem_data_in,
    input  mem_data_out, MFC, busy
  );

  modport slave (
    input  MEM_EN, MEM_RW, mem_addr, mem_data_in,
    output mem_data_out, MFC, busy
  );
endinterface

// File: rtl/mem_unit.sv
// Word-addressed main memory with a fixed access latency; one access in flight.
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous active-low reset (aborts any access, array kept)
//   bus    mem_unit_if slave: request strobes in, read data / MFC / busy out
module mem_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_unit_if.slave   bus
);

  localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_RAW = $clog2(LATENCY + 1);
  localparam int unsigned CNT_W   = (CNT_RAW < 4) ? 4 : CNT_RAW;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  mfc_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic done_c;
  logic wr_en_c;

  // Completion edge: last BUSY cycle; writes commit only when not in reset.
  assign done_c  = (state == BUSY) && (cnt == '0);
  assign wr_en_c = done_c && !rw_q && reset;

  // Storage array: synchronous write port, never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Access control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      rdata_q <= '0;
      mfc_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.MEM_EN) begin
        addr_q  <= bus.mem_addr;
        wdata_q <= bus.mem_data_in;
        rw_q    <= bus.MEM_RW;
        cnt     <= CNT_W'(LATENCY - 1);
        mfc_q   <= 1'b1;
        busy_q  <= 1'b1;
        state   <= BUSY;
      end
    end else begin
      // Requests seen while BUSY, including on the completion edge, are dropped.
      if (cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end else begin
        if (rw_q) begin
          rdata_q <= mem[addr_q];
        end
        mfc_q  <= 1'b0;
        busy_q <= 1'b0;
        state  <= IDLE;
      end
    end
  end

  assign bus.mem_data_out = rdata_q;
  assign bus.MFC          = mfc_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: reset, table-driven directed accesses, reset abort,
// randomized accesses against an array model, and a load-FSM handshake
// on a LATENCY=3 instance.
module tb_mem_unit;

  logic clk;
  logic reset;

  mem_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();
  mem_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus3 ();

  mem_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mem_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] mdl [256];
  logic [15:0] last_rd;

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] data;
    int          ign_at;
    logic [15:0] exp_rd;
    int          exp_hi;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One access on bus; starts #1 after an edge. Optionally pulses a stray
  // write request before the ign_at-th BUSY edge. Returns read data and MFC-high count.
  task automatic access(input logic rw, input logic [7:0] a, input logic [15:0] d,
                        input int ign_at, input logic [15:0] ign_d,
                        output logic [15:0] rd, output int hi);
    bus.MEM_EN      = 1'b1;
    bus.MEM_RW      = rw;
    bus.mem_addr    = a;
    bus.mem_data_in = d;
    @(posedge clk); #1;
    bus.MEM_EN      = 1'b0;
    bus.MEM_RW      = 1'($urandom);
    bus.mem_addr    = 8'($urandom);
    bus.mem_data_in = 16'($urandom);
    hi = 0;
    while (bus.MFC === 1'b1 && hi < 40) begin
      hi++;
      if (hi == ign_at) begin
        bus.MEM_EN      = 1'b1;
        bus.MEM_RW      = 1'b0;
        bus.mem_addr    = a;
        bus.mem_data_in = ign_d;
      end
      @(posedge clk); #1;
      bus.MEM_EN = 1'b0;
    end
    rd = bus.mem_data_out;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    int          hi;
    int          n;
    logic [15:0] mdr;
    logic [7:0]  a;
    logic [15:0] d;
    logic        rw;
    int          ign;

    vt[0] = '{1'b0, 8'h12, 16'hBEEF, -1, 16'h0000, 2};
    vt[1] = '{1'b1, 8'h12, 16'h0000, -1, 16'hBEEF, 2};
    vt[2] = '{1'b1, 8'h12, 16'h0000,  1, 16'hBEEF, 2};
    vt[3] = '{1'b1, 8'h12, 16'h0000,  2, 16'hBEEF, 2};
    vt[4] = '{1'b0, 8'h00, 16'h00A5, -1, 16'hBEEF, 2};
    vt[5] = '{1'b1, 8'h00, 16'h0000, -1, 16'h00A5, 2};
    vt[6] = '{1'b1, 8'h12, 16'h0000, -1, 16'hBEEF, 2};

    bus3.MEM_EN = 1'b0; bus3.MEM_RW = 1'b0; bus3.mem_addr = '0; bus3.mem_data_in = '0;

    // Reset held for two edges with a request pending
    reset = 1'b0;
    bus.MEM_EN = 1'b1; bus.MEM_RW = 1'b1; bus.mem_addr = 8'h12; bus.mem_data_in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mfc",  32'(bus.MFC), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dout", 32'(bus.mem_data_out), 32'd0);
    bus.MEM_EN = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_no_access", 32'(bus.MFC), 32'd0);

    // Fill the whole array with known contents
    for (int i = 0; i < 256; i++) begin
      mdl[i] = 16'((i * 16'h0101) ^ 16'h3C3C);
      access(1'b0, 8'(i), mdl[i], -1, 16'h0, rd, hi);
    end
    last_rd = 16'h0000;

    // Directed table: write/read, ignored requests, back-to-back
    for (int i = 0; i < 7; i++) begin
      access(vt[i].rw, vt[i].addr, vt[i].data, vt[i].ign_at, 16'h1111, rd, hi);
      chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vt[i].exp_rd));
      chk($sformatf("vec%0d_mfc_cycles", i), 32'(hi), 32'(vt[i].exp_hi));
      chk($sformatf("vec%0d_busy_idle", i), 32'(bus.busy), 32'd0);
      if (!vt[i].rw) mdl[vt[i].addr] = vt[i].data;
      last_rd = rd;
    end

    // Reset one cycle into a write: aborted, nothing committed
    bus.MEM_EN = 1'b1; bus.MEM_RW = 1'b0; bus.mem_addr = 8'h30; bus.mem_data_in = 16'h5A5A;
    @(posedge clk); #1;
    bus.MEM_EN = 1'b0;
    chk("abort_mfc_inflight", 32'(bus.MFC), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_mfc", 32'(bus.MFC), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_dout", 32'(bus.mem_data_out), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 8'h30, 16'h0, -1, 16'h0, rd, hi);
    chk("abort_readback", 32'(rd), 32'(mdl[8'h30]));
    last_rd = rd;

    // Randomized accesses against the array model
    for (int k = 0; k < 300; k++) begin
      rw  = 1'($urandom);
      a   = 8'($urandom);
      d   = 16'($urandom);
      ign = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : -1;
      access(rw, a, d, ign, 16'($urandom), rd, hi);
      chk("rand_mfc_cycles", 32'(hi), 32'd2);
      if (rw) begin
        chk("rand_read", 32'(rd), 32'(mdl[a]));
        last_rd = mdl[a];
      end else begin
        chk("rand_write_hold", 32'(rd), 32'(last_rd));
        mdl[a] = d;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    // LATENCY=3 instance: preload array[0x05] then run the load-FSM handshake
    bus3.MEM_EN = 1'b1; bus3.MEM_RW = 1'b0; bus3.mem_addr = 8'h05; bus3.mem_data_in = 16'h0042;
    @(posedge clk); #1;
    bus3.MEM_EN = 1'b0;
    n = 0;
    while (bus3.MFC === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("l3_write_cycles", 32'(n), 32'd3);

    // st1: pulse MEM_EN as a read; WAIT1 while MFC; then MDR captures
    bus3.MEM_EN = 1'b1; bus3.MEM_RW = 1'b1; bus3.mem_addr = 8'h05; bus3.mem_data_in = 16'hFFFF;
    @(posedge clk); #1;
    bus3.MEM_EN = 1'b0;
    n = 0;
    while (bus3.MFC === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    mdr = bus3.mem_data_out;
    chk("l3_wait1_cycles", 32'(n), 32'd3);
    chk("l3_mdr", 32'(mdr), 32'h0042);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_unit.md
Name: mem_unit

Overview:
- Word-addressed main memory with a fixed, parameterised access latency.
- Sits directly downstream of the load/store control FSMs and consumes their bus strobes: MAR address, MDR write data, MEM_EN, MEM_RW.
- Returns read data toward MDR and signals completion on MFC, which the FSM wait states poll.
- One outstanding access at a time; no pipelining.

Parameters:
- DATA_WIDTH, 16, width of a memory word and of both data buses
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH words
- LATENCY, 2, cycles MFC stays high per access; legal range 1..15

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on the clk rising edge)
- MEM_EN  input  1  access request strobe; sampled only in IDLE
- MEM_RW  input  1  access type; 1 = read, 0 = write; sampled with MEM_EN
- mem_addr  input  ADDR_WIDTH  address from MAR; sampled with MEM_EN
- mem_data_in  input  DATA_WIDTH  store data from MDR; sampled with MEM_EN
- mem_data_out  output  DATA_WIDTH  read data for MDR; registered; held until the next read completes
- MFC  output  1  memory-function-complete flag; 1 while an access is in flight, 0 when idle or complete
- busy  output  1  1 in BUSY state; mirrors MFC, provided for other bus masters

Behaviour:
- Reset: on a clk edge with reset = 0:
  - state = IDLE; MFC = 0; busy = 0; mem_data_out = 0; latency counter = 0.
  - Any latched address, data or rw is discarded.
  - Memory array contents are NOT cleared.
- States: IDLE, BUSY. The counter is $clog2(LATENCY+1) bits, minimum 4.
- IDLE:
  - On an edge with MEM_EN = 1: latch mem_addr, mem_data_in and MEM_RW.
  - Load counter = LATENCY-1; MFC <= 1; go to BUSY.
  - With MEM_EN = 0: remain in IDLE.
- BUSY with counter > 0: decrement each edge; MFC stays 1.
- BUSY with counter == 0 (completion edge):
  - Read: mem_data_out <= array[latched addr].
  - Write: array[latched addr] <= latched data; mem_data_out unchanged.
  - MFC <= 0; go to IDLE.
- Latency: MFC is high for exactly LATENCY cycles following the request edge.
  - Read data is valid in the first cycle that MFC is 0 again.
  - FSM consumer rule: the consumer waits while MFC = 1 and proceeds on MFC = 0.
- MEM_EN while BUSY, including the completion edge, is ignored entirely: no queuing, no error.
- A request in the first IDLE cycle after completion is accepted (back-to-back accesses allowed).
- MEM_EN held high for multiple IDLE cycles: each acceptance starts a new access.
  - A level held through BUSY is therefore re-accepted once IDLE is reached.
  - Controllers must pulse MEM_EN for one cycle.
- Read-after-write to the same address returns the written value.
  - The write commits on its completion edge, before any later read can be accepted.
- Inputs are sampled only on the request edge. Changes to mem_addr, mem_data_in or MEM_RW during BUSY have no effect.
- Reset mid-access: the access is aborted.
  - A pending write is NOT committed.
  - MFC drops to 0 on the reset edge; mem_data_out = 0.
- The array is inferred as a register array with a synchronous write port. There is no combinational read path to mem_data_out.

Test Plan:
1. Reset: drive reset = 0 for 2 edges with MEM_EN = 1 -> MFC = 0, busy = 0, mem_data_out = 0, no access started.
2. Write then read, LATENCY = 2:
   - Write 0xBEEF to addr 0x12, MEM_EN pulsed at edge E0 -> MFC = 1 after E0 and after E1, MFC = 0 after E2.
   - Then read 0x12 -> mem_data_out = 0xBEEF in the first cycle MFC = 0.
3. Ignored request: during BUSY of a read of 0x12, pulse MEM_EN with a write of 0x1111 to 0x12 -> no effect; a later read of 0x12 still returns 0xBEEF; MFC high exactly 2 cycles.
4. Back-to-back:
   - Write 0x00A5 to 0x00.
   - Read 0x00 requested in the first IDLE cycle after completion -> accepted immediately; returns 0x00A5.
5. Reset mid-write: write 0x5A5A to 0x30, assert reset = 0 one cycle after the request -> MFC = 0 next edge; a subsequent read of 0x30 returns its prior value (0x0000 if written 0x0000 earlier).
6. Load-FSM handshake: connect the load FSM (st1 pulses MEM_EN, MEM_RW = 1) with LATENCY = 3 and array[0x05] = 0x0042 -> the FSM holds in WAIT1 for exactly 3 cycles; MDR captures 0x0042; done asserts.
